// File: rtl/frame_pacer.sv
// Frame scheduler: paces frame starts to one per FRAME_PERIOD clocks, waits for
// the refresh engine to finish each frame, and aborts frames that never finish.
module frame_pacer #(
  parameter int unsigned FRAME_PERIOD = 3_333_333,
  parameter int unsigned TIMEOUT      = 4_000_000
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       enable_in,
  input  logic       frame_rdy_in,
  input  logic       frame_done_in,
  input  logic       clr_err_in,
  output logic       frame_start_out,
  output logic       frame_pulse_out,
  output logic       busy_out,
  output logic       timeout_out,
  output logic [7:0] drop_cnt_out
);

  localparam logic [31:0] SLOT_LAST = 32'(FRAME_PERIOD - 1);
  localparam logic [31:0] WDT_LAST  = 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, START, RUN} state_t;

  state_t      state, state_nx;
  logic [31:0] period_cnt;
  logic [31:0] wdt;
  logic        slot_open;
  logic        done_hit;
  logic        abort;

  assign slot_open = (period_cnt == SLOT_LAST);

  // done beats a watchdog expiry landing in the same cycle
  always_comb begin
    state_nx = state;
    done_hit = 1'b0;
    abort    = 1'b0;
    case (state)
      IDLE:  if (enable_in) state_nx = WAIT;
      WAIT: begin
        if (!enable_in)                      state_nx = IDLE;
        else if (frame_rdy_in && slot_open)  state_nx = START;
      end
      START: state_nx = RUN;
      RUN: begin
        if (frame_done_in) begin
          done_hit = 1'b1;
          state_nx = enable_in ? WAIT : IDLE;
        end else if (wdt == WDT_LAST) begin
          abort    = 1'b1;
          state_nx = enable_in ? WAIT : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_nx;
  end

  // preset to the last slot value so the first frame after reset goes out at once
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      period_cnt <= SLOT_LAST;
      wdt        <= '0;
    end else begin
      if (state_nx == START)       period_cnt <= '0;
      else if (!slot_open)         period_cnt <= period_cnt + 32'd1;
      if (state == START)          wdt <= '0;
      else if (state == RUN)       wdt <= wdt + 32'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      frame_start_out <= 1'b0;
      frame_pulse_out <= 1'b0;
      busy_out        <= 1'b0;
      timeout_out     <= 1'b0;
      drop_cnt_out    <= '0;
    end else begin
      frame_start_out <= (state_nx == START);
      frame_pulse_out <= done_hit;
      busy_out        <= (state_nx == START) || (state_nx == RUN);
      // an abort coinciding with a clear still records itself
      if (abort) begin
        timeout_out  <= 1'b1;
        drop_cnt_out <= clr_err_in ? 8'd1 :
                        (drop_cnt_out == 8'hff) ? 8'hff : drop_cnt_out + 8'd1;
      end else if (clr_err_in) begin
        timeout_out  <= 1'b0;
        drop_cnt_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_frame_pacer.sv
// Bench for frame_pacer: directed scenarios plus random traffic, all checked
// cycle by cycle against a timestamp-based reference model.
module tb_frame_pacer;
  localparam int FP = 10;
  localparam int TO = 20;

  logic       clk_in = 1'b0;
  logic       rst_n_in = 1'b0;
  logic       enable_in = 1'b0;
  logic       frame_rdy_in = 1'b0;
  logic       frame_done_in = 1'b0;
  logic       clr_err_in = 1'b0;
  logic       frame_start_out, frame_pulse_out, busy_out, timeout_out;
  logic [7:0] drop_cnt_out;

  int checks = 0;
  int errors = 0;
  int cyc, since;

  // model: m_sc = START cycle of the frame in flight, m_last = last START cycle
  bit m_armed, m_frame, m_to;
  int m_sc, m_last, m_drop;
  bit e_start, e_pulse, e_busy;

  logic [11:0] obs, expv;
  assign obs  = {frame_start_out, frame_pulse_out, busy_out, timeout_out, drop_cnt_out};
  assign expv = {e_start, e_pulse, e_busy, m_to, 8'(m_drop)};

  frame_pacer #(.FRAME_PERIOD(FP), .TIMEOUT(TO)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .enable_in(enable_in),
    .frame_rdy_in(frame_rdy_in), .frame_done_in(frame_done_in),
    .clr_err_in(clr_err_in), .frame_start_out(frame_start_out),
    .frame_pulse_out(frame_pulse_out), .busy_out(busy_out),
    .timeout_out(timeout_out), .drop_cnt_out(drop_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "time limit");
  end

  task automatic model_reset();
    cyc = 0; m_armed = 0; m_frame = 0; m_to = 0;
    m_sc = 0; m_last = -FP; m_drop = 0;
    e_start = 0; e_pulse = 0; e_busy = 0;
  endtask

  // advance one clock: model consumes this cycle's inputs, then wait for the falling edge
  task automatic step();
    bit ab;
    @(posedge clk_in);
    ab = 0; e_start = 0; e_pulse = 0;
    if (m_frame) begin
      if (cyc != m_sc) begin
        if (frame_done_in) begin
          e_pulse = 1; m_frame = 0; m_armed = enable_in;
        end else if (cyc - m_sc == TO) begin
          ab = 1; m_frame = 0; m_armed = enable_in;
        end
      end
    end else if (m_armed) begin
      if (!enable_in) m_armed = 0;
      else if (frame_rdy_in && (cyc - m_last >= FP - 1)) begin
        m_frame = 1; m_armed = 0; m_sc = cyc + 1; m_last = cyc + 1; e_start = 1;
      end
    end else if (enable_in) m_armed = 1;
    if (ab) begin
      m_to = 1;
      m_drop = clr_err_in ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
    end else if (clr_err_in) begin
      m_to = 0; m_drop = 0;
    end
    e_busy = m_frame;
    cyc++;
    @(negedge clk_in);
    if (frame_start_out) since = 0;
    else if (since < 100000) since++;
  endtask

  task automatic test_reset();
    rst_n_in = 0; enable_in = 0; frame_rdy_in = 0; frame_done_in = 0; clr_err_in = 0;
    model_reset();
    repeat (2) @(negedge clk_in);
    checks++;
    if (obs !== 12'h000) begin
      errors++; $display("FAIL reset_state got %h want 000", obs);
    end
    rst_n_in = 1; since = 100000;
  endtask

  task automatic test_first_start();
    int first = -1;
    enable_in = 1; frame_rdy_in = 1;
    for (int n = 1; n <= 8; n++) begin
      step();
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL first_start cyc=%0d got %h want %h", cyc, obs, expv);
      end
      if (frame_start_out && first < 0) begin
        first = n;
        checks++;
        if (busy_out !== 1'b1) begin
          errors++; $display("FAIL first_busy got %b want 1", busy_out);
        end
      end
      frame_done_in = (since == 3);
    end
    checks++;
    if (first != 2) begin
      errors++; $display("FAIL first_latency got %0d want 2", first);
    end
  endtask

  task automatic test_periodic();
    int starts = 0, pulses = 0, last = -1;
    enable_in = 1; frame_rdy_in = 1;
    for (int n = 0; n < 1200 && !(starts == 100 && since > 8); n++) begin
      step();
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL periodic cyc=%0d got %h want %h", cyc, obs, expv);
      end
      if (frame_start_out) begin
        if (starts > 0) begin
          checks++;
          if (cyc - last != FP) begin
            errors++; $display("FAIL periodic_spacing got %0d want %0d", cyc - last, FP);
          end
        end
        last = cyc; starts++;
        if (starts == 100) enable_in = 0;
      end
      if (frame_pulse_out) pulses++;
      frame_done_in = (since == 3);
    end
    frame_done_in = 0;
    checks++;
    if (starts != 100 || pulses != 100) begin
      errors++; $display("FAIL periodic_count got starts=%0d pulses=%0d want 100/100", starts, pulses);
    end
  endtask

  task automatic test_timeout();
    int starts = 0, first_to = -1, last = 0;
    since = 100000; frame_done_in = 0; enable_in = 1; frame_rdy_in = 1;
    for (int n = 0; n < 7500 && !(starts == 300 && !busy_out); n++) begin
      step();
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL timeout cyc=%0d got %h want %h", cyc, obs, expv);
      end
      if (frame_start_out) begin
        last = cyc; starts++;
        if (starts == 300) enable_in = 0;
      end
      if (timeout_out && first_to < 0) begin
        first_to = cyc - last;
        checks++;
        if (first_to != 21 || drop_cnt_out !== 8'd1) begin
          errors++; $display("FAIL first_abort got delay=%0d drop=%0d want 21/1", first_to, drop_cnt_out);
        end
      end
    end
    checks++;
    if (timeout_out !== 1'b1 || drop_cnt_out !== 8'd255 || starts != 300) begin
      errors++;
      $display("FAIL drop_saturate got to=%b drop=%0d starts=%0d want 1/255/300", timeout_out, drop_cnt_out, starts);
    end
    clr_err_in = 1;
    step();
    clr_err_in = 0;
    checks++;
    if (timeout_out !== 1'b0 || drop_cnt_out !== 8'd0) begin
      errors++; $display("FAIL clear_err got to=%b drop=%0d want 0/0", timeout_out, drop_cnt_out);
    end
  endtask

  task automatic test_done_vs_wdt();
    int pulses = 0, seen = -1;
    since = 100000; clr_err_in = 0; enable_in = 1; frame_rdy_in = 1;
    for (int n = 0; n < 60; n++) begin
      step();
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL done_race cyc=%0d got %h want %h", cyc, obs, expv);
      end
      if (frame_pulse_out) begin
        pulses++; enable_in = 0;
        if (seen < 0) seen = since;
      end
      frame_done_in = (since == 20);
    end
    checks++;
    if (pulses != 1 || seen != 21 || timeout_out !== 1'b0) begin
      errors++; $display("FAIL done_race_result got pulses=%0d at=%0d to=%b want 1/21/0", pulses, seen, timeout_out);
    end
    since = 100000; frame_done_in = 0; enable_in = 1;
    for (int n = 0; n < 60; n++) begin
      step();
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL clr_race cyc=%0d got %h want %h", cyc, obs, expv);
      end
      if (timeout_out) enable_in = 0;
      clr_err_in = (since == 20);
    end
    clr_err_in = 0;
    checks++;
    if (timeout_out !== 1'b1 || drop_cnt_out !== 8'd1) begin
      errors++; $display("FAIL clr_race_result got to=%b drop=%0d want 1/1", timeout_out, drop_cnt_out);
    end
  endtask

  task automatic test_enable_drop();
    int starts = 0, pulses = 0;
    since = 100000; enable_in = 1; frame_rdy_in = 1; frame_done_in = 0;
    for (int n = 0; n < 60; n++) begin
      step();
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL enable_drop cyc=%0d got %h want %h", cyc, obs, expv);
      end
      if (frame_start_out) starts++;
      if (frame_pulse_out) pulses++;
      enable_in = (starts == 0);
      frame_done_in = (since == 3) || (since > 10 && since % 4 == 0);
    end
    frame_done_in = 0;
    checks++;
    if (starts != 1 || pulses != 1 || busy_out !== 1'b0) begin
      errors++; $display("FAIL enable_drop_result got starts=%0d pulses=%0d busy=%b want 1/1/0", starts, pulses, busy_out);
    end
  endtask

  task automatic test_reset_mid();
    int first = -1;
    since = 100000; enable_in = 1; frame_rdy_in = 1; frame_done_in = 0;
    for (int n = 0; n < 20 && !(busy_out && since == 5); n++) begin
      step();
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL reset_mid_pre cyc=%0d got %h want %h", cyc, obs, expv);
      end
    end
    checks++;
    if (!(busy_out && since == 5)) begin
      errors++; $display("FAIL reset_mid_reach got busy=%b since=%0d want 1/5", busy_out, since);
    end
    #2 rst_n_in = 0;
    #1;
    checks++;
    if (obs !== 12'h000) begin
      errors++; $display("FAIL reset_async got %h want 000", obs);
    end
    model_reset();
    @(negedge clk_in);
    rst_n_in = 1; since = 100000;
    for (int n = 1; n <= 15; n++) begin
      step();
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL reset_mid_post cyc=%0d got %h want %h", cyc, obs, expv);
      end
      if (frame_start_out && first < 0) first = n;
      if (first >= 0) enable_in = 0;
      frame_done_in = (since == 3);
    end
    frame_done_in = 0;
    checks++;
    if (first != 2) begin
      errors++; $display("FAIL reset_mid_restart got %0d want 2", first);
    end
  endtask

  task automatic test_random();
    since = 100000;
    for (int n = 0; n < 3000; n++) begin
      enable_in     = ($urandom_range(0, 15) != 0);
      frame_rdy_in  = ($urandom_range(0, 1) == 1);
      frame_done_in = (n < 1500) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 39) == 0);
      clr_err_in    = ($urandom_range(0, 63) == 0);
      step();
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL random cyc=%0d got %h want %h", cyc, obs, expv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_start();
    test_periodic();
    test_timeout();
    test_done_vs_wdt();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
